clk_reset_seq: RTL and testbench
================================

# clk_reset_seq

Reset sequencer and clock-enable generator in the 50 MHz system clock domain, directly downstream of the system PLL. It synchronises the PLL `locked` flag and holds the system and CPU resets until the clock is stable. It then releases them in order. After release it produces phase-deterministic single-cycle enables for the 25 MHz video pixel logic and the 6.25 MHz Gigatron CPU, so the core runs entirely on one clock.

## Interface
- `HOLD_CYCLES`, 1024: system-reset hold time in clk cycles after lock is seen; legal range ≥ 2.
- `CPU_RST_EXTRA`, 16: extra cycles `cpu_reset` stays high after `reset_out` falls; legal range ≥ 1.
- `CE_PIX_DIV`, 2: pixel enable divider; power of two, ≥ 2.
- `CE_CPU_DIV`, 8: CPU enable divider; power of two, integer multiple of `CE_PIX_DIV`.

Ports:
- `clk` in 1: 50 MHz system clock (PLL output 0).
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock flag; asynchronous to `clk`, synchronised internally.
- `warm_reset` in 1: synchronous CPU-only reset request (OSD/menu); level-sensitive.
- `reset_out` out 1: system reset for video/memory logic, active-high, registered.
- `cpu_reset` out 1: CPU reset, active-high, registered.
- `ce_pix` out 1: one-cycle pixel enable, registered.
- `ce_cpu` out 1: one-cycle CPU enable, registered.
- `ready` out 1: high only in RUN.

## Operation
- Only one clock and one reset are used. `rst` is synchronous and active-high.
- Reset values: state WAIT_LOCK, `reset_out`=1, `cpu_reset`=1, `ce_pix`=0, `ce_cpu`=0, `ready`=0. All counters and both synchroniser flops are 0.
- `pll_locked` passes through a 2-flop synchroniser to give `locked_s`. Nothing else samples the raw input.
- **WAIT_LOCK**: both resets high, enables 0, hold counter 0. Go to HOLD when `locked_s`=1.
- **HOLD**: both resets high, enables 0. The hold counter increments each cycle. After `HOLD_CYCLES` cycles in HOLD, go to CPU_HOLD.
- **CPU_HOLD**: `reset_out`=0, `cpu_reset`=1, enables run. Go to RUN after `CPU_RST_EXTRA` cycles.
- **RUN**: both resets 0, `ready`=1.
- Lock loss: `locked_s`=0 in any state forces WAIT_LOCK on the next edge. Both resets are reasserted, enables are forced to 0, and all counters are cleared.
- `warm_reset`=1 in CPU_HOLD or RUN forces CPU_HOLD and restarts its counter. `cpu_reset` stays high while `warm_reset` is held, then for `CPU_RST_EXTRA` cycles after it falls. `reset_out` and the enable phase are not disturbed. `warm_reset` is ignored in WAIT_LOCK and HOLD.
- Simultaneous lock loss and `warm_reset`: lock loss wins.
- Enable counters: `cnt_pix` (mod `CE_PIX_DIV`) and `cnt_cpu` (mod `CE_CPU_DIV`).
  - Both are held at 0 in WAIT_LOCK and HOLD.
  - Both count freely in CPU_HOLD and RUN and wrap without saturating.
- Enable phase: number cycles from n=0, the first cycle with `reset_out`=0.
  - `ce_pix`=1 at n = k·`CE_PIX_DIV` − 1.
  - `ce_cpu`=1 at n = k·`CE_CPU_DIV` − 1, for k ≥ 1.
  - Every `ce_cpu` pulse therefore coincides with a `ce_pix` pulse.
- Enables also pulse during CPU_HOLD, so the CPU samples its reset on enabled cycles.

## Timing
- `pll_locked` first sampled high at edge t gives `locked_s`=1 after edge t+1 and state HOLD after edge t+2.
- `reset_out` falls exactly `HOLD_CYCLES` cycles after HOLD is entered.
- `cpu_reset` falls exactly `CPU_RST_EXTRA` cycles after `reset_out` falls; `ready` rises in the same cycle.
- Lock loss sampled at edge t: resets are high and enables are 0 from edge t+3 at the latest (2 sync + 1 state).
- `warm_reset` sampled high at edge t: `cpu_reset`=1 from the cycle after edge t.
- `rst` mid-operation: all outputs return to their reset values on the next edge.
- Outputs carry no combinational path from any input.

## Test plan
- Cold start (`HOLD_CYCLES`=8, `CPU_RST_EXTRA`=4): raise `pll_locked` at cycle 10. Required: HOLD at cycle 12, `reset_out` falls at 20, `cpu_reset` and `ready` rise/fall as specified at 24.
- Enable phase with defaults, after release: `ce_pix` high at n=1,3,5…; `ce_cpu` high at n=7,15,23…; exactly 4 `ce_pix` per `ce_cpu`; pattern identical across two separate cold starts.
- Lock loss: drop `pll_locked` for 1 cycle in RUN. Required: resets high and enables 0 within 3 cycles, then a full HOLD/CPU_HOLD sequence after relock.
- Warm reset: pulse `warm_reset` for 5 cycles in RUN. Required: `cpu_reset` high for 5+4 cycles, `reset_out` stays 0, `ce_pix`/`ce_cpu` phase unchanged.
- `warm_reset` held during HOLD: no effect on timing.
- Simultaneous lock loss and `warm_reset`: required result is WAIT_LOCK.
- Synchronous `rst` asserted mid-CPU_HOLD: all outputs at reset values on the next edge; sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/clk_reset_seq.sv
// rtl/clk_reset_seq.sv - reset sequencer and phase-locked clock-enable generator
module clk_reset_seq #(
  parameter int HOLD_CYCLES   = 1024,
  parameter int CPU_RST_EXTRA = 16,
  parameter int CE_PIX_DIV    = 2,
  parameter int CE_CPU_DIV    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic warm_reset,
  output logic reset_out,
  output logic cpu_reset,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ready
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int XTRA_W = $clog2(CPU_RST_EXTRA + 1);
  localparam int PIX_W  = $clog2(CE_PIX_DIV);
  localparam int CPU_W  = $clog2(CE_CPU_DIV);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    CPU_HOLD  = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t             state;
  logic               sync1;
  logic               locked_s;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [XTRA_W-1:0]  cpu_cnt;
  logic [PIX_W-1:0]   cnt_pix;
  logic [CPU_W-1:0]   cnt_cpu;
  logic [PIX_W-1:0]   pix_nxt;
  logic [CPU_W-1:0]   cpu_nxt;

  // Power-of-two dividers wrap naturally; the pixel counter always equals the
  // low bits of the CPU counter, so every ce_cpu lands on a ce_pix.
  always_comb begin
    pix_nxt = cnt_pix + PIX_W'(1);
    cpu_nxt = cnt_cpu + CPU_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      sync1     <= 1'b0;
      locked_s  <= 1'b0;
      hold_cnt  <= '0;
      cpu_cnt   <= '0;
      cnt_pix   <= '0;
      cnt_cpu   <= '0;
      reset_out <= 1'b1;
      cpu_reset <= 1'b1;
      ce_pix    <= 1'b0;
      ce_cpu    <= 1'b0;
      ready     <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      if (!locked_s) begin
        state     <= WAIT_LOCK;
        hold_cnt  <= '0;
        cpu_cnt   <= '0;
        cnt_pix   <= '0;
        cnt_cpu   <= '0;
        reset_out <= 1'b1;
        cpu_reset <= 1'b1;
        ce_pix    <= 1'b0;
        ce_cpu    <= 1'b0;
        ready     <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
          HOLD: begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
              state     <= CPU_HOLD;
              reset_out <= 1'b0;
              cpu_cnt   <= XTRA_W'(1);
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          CPU_HOLD, RUN: begin
            cnt_pix <= pix_nxt;
            cnt_cpu <= cpu_nxt;
            ce_pix  <= &pix_nxt;
            ce_cpu  <= &cpu_nxt;
            // A warm request parks the counter one step below the cold-start
            // entry value, so release comes CPU_RST_EXTRA cycles after the
            // first edge that sees the request gone.
            if (warm_reset) begin
              state     <= CPU_HOLD;
              cpu_reset <= 1'b1;
              ready     <= 1'b0;
              cpu_cnt   <= '0;
            end else if (state == CPU_HOLD) begin
              if (cpu_cnt == XTRA_W'(CPU_RST_EXTRA)) begin
                state     <= RUN;
                cpu_reset <= 1'b0;
                ready     <= 1'b1;
              end else begin
                cpu_cnt <= cpu_cnt + XTRA_W'(1);
              end
            end
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_reset_seq.sv
// tb/tb_clk_reset_seq.sv - self-checking bench for clk_reset_seq
module tb_clk_reset_seq;
  localparam int HOLD  = 8;
  localparam int EXTRA = 4;
  localparam int PIX   = 2;
  localparam int CPU   = 8;

  logic clk = 1'b0;
  logic rst, pll_locked, warm_reset;
  logic reset_out, cpu_reset, ce_pix, ce_cpu, ready;

  always #10 clk = ~clk;

  clk_reset_seq #(
    .HOLD_CYCLES(HOLD), .CPU_RST_EXTRA(EXTRA), .CE_PIX_DIV(PIX), .CE_CPU_DIV(CPU)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .warm_reset(warm_reset),
    .reset_out(reset_out), .cpu_reset(cpu_reset), .ce_pix(ce_pix),
    .ce_cpu(ce_cpu), .ready(ready)
  );

  int checks = 0;
  int failures = 0;

  // Timestamp model: edge of HOLD entry, of system release, of last warm request.
  int   e   = 0;
  int   hs  = -1;
  int   rel = -1;
  int   lw  = -100;
  logic p1  = 1'b0;
  logic p2  = 1'b0;
  logic [4:0] exp_o = 5'b11000;
  wire  [4:0] act_o = {reset_out, cpu_reset, ce_pix, ce_cpu, ready};

  function automatic logic [4:0] expect_out();
    int n, crel;
    logic cr;
    if (rel < 0) return 5'b11000;
    n    = e - rel;
    crel = ((lw + 1 > rel) ? lw + 1 : rel) + EXTRA;
    cr   = (e < crel);
    return {1'b0, cr, ((n + 1) % PIX) == 0, ((n + 1) % CPU) == 0, !cr};
  endfunction

  task automatic step();
    logic ls;
    @(posedge clk);
    e++;
    ls = p2;
    if (rst) begin
      p1 = 1'b0; p2 = 1'b0; hs = -1; rel = -1; lw = -100;
    end else begin
      p2 = p1;
      p1 = pll_locked;
      if (!ls) begin
        hs = -1; rel = -1;
      end else if (hs < 0) begin
        hs = e;
      end else if (rel < 0) begin
        if (e - hs == HOLD) begin rel = e; lw = -100; end
      end else if (warm_reset) begin
        lw = e;
      end
    end
    exp_o = expect_out();
    @(negedge clk);
  endtask

  task automatic wait_run();
    pll_locked = 1'b1; warm_reset = 1'b0; rst = 1'b0;
    for (int i = 0; i < 80 && exp_o[0] !== 1'b1; i++) step();
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_run ready got=%b want=1", ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'($urandom); warm_reset = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (act_o !== 5'b11000) begin
        failures++;
        $display("FAIL reset_values got=%b want=11000", act_o);
      end
    end
  endtask

  task automatic test_cold_start();
    int t;
    rst = 1'b0; pll_locked = 1'b0; warm_reset = 1'b0;
    for (int i = 0; i < 9; i++) step();
    pll_locked = 1'b1;
    t = e + 1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        $display("FAIL cold_model e=%0d got=%b want=%b", e - t, act_o, exp_o);
      end
      if (e == t + 1 + HOLD || e == t + 2 + HOLD) begin
        checks++;
        if (reset_out !== (e == t + 1 + HOLD)) begin
          failures++;
          $display("FAIL cold_reset_out_edge e=%0d got=%b", e - t, reset_out);
        end
      end
      if (e == t + 1 + HOLD + EXTRA || e == t + 2 + HOLD + EXTRA) begin
        checks++;
        if ({cpu_reset, ready} !== ((e == t + 1 + HOLD + EXTRA) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL cold_cpu_release e=%0d got=%b%b", e - t, cpu_reset, ready);
        end
      end
    end
  endtask

  task automatic test_enable_phase();
    logic [63:0] pat [2];
    int pix_cnt;
    for (int r = 0; r < 2; r++) begin
      rst = 1'b1; step(); rst = 1'b0; pll_locked = 1'b0; warm_reset = 1'b0;
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) step();
      pll_locked = 1'b1;
      for (int i = 0; i < 40 && rel < 0; i++) step();
      checks++;
      if (reset_out !== 1'b0) begin
        failures++;
        $display("FAIL phase_release got=%b want=0", reset_out);
      end
      pix_cnt = 0;
      pat[r] = '0;
      for (int n = 0; n < 32; n++) begin
        pat[r][2*n +: 2] = {ce_pix, ce_cpu};
        checks++;
        if ({ce_pix, ce_cpu} !== {1'((n + 1) % PIX == 0), 1'((n + 1) % CPU == 0)}) begin
          failures++;
          $display("FAIL phase_n n=%0d got=%b%b", n, ce_pix, ce_cpu);
        end
        if (ce_pix === 1'b1) pix_cnt++;
        if (ce_cpu === 1'b1) begin
          checks++;
          if (pix_cnt !== 4) begin
            failures++;
            $display("FAIL pix_per_cpu got=%0d want=4", pix_cnt);
          end
          pix_cnt = 0;
        end
        step();
      end
    end
    checks++;
    if (pat[1] !== pat[0]) begin
      failures++;
      $display("FAIL phase_repeat got=%h want=%h", pat[1], pat[0]);
    end
  endtask

  task automatic test_lock_loss();
    wait_run();
    for (int i = 0; i < int'($urandom_range(0, 10)); i++) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    for (int k = 0; k < HOLD + EXTRA + 12; k++) begin
      step();
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        $display("FAIL lockloss_model k=%0d got=%b want=%b", k, act_o, exp_o);
      end
      if (k == 1) begin
        checks++;
        if ({reset_out, cpu_reset, ce_pix, ce_cpu} !== 4'b1100) begin
          failures++;
          $display("FAIL lockloss_3cyc got=%b want=1100", {reset_out, cpu_reset, ce_pix, ce_cpu});
        end
      end
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL lockloss_relock ready got=%b want=1", ready);
    end
  endtask

  task automatic test_warm();
    int hi;
    wait_run();
    for (int i = 0; i < int'($urandom_range(0, 7)); i++) step();
    warm_reset = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) warm_reset = 1'b0;
      step();
      if (cpu_reset === 1'b1) hi++;
      checks++;
      if (act_o !== exp_o || reset_out !== 1'b0) begin
        failures++;
        $display("FAIL warm_model i=%0d got=%b want=%b", i, act_o, exp_o);
      end
    end
    checks++;
    if (hi !== 5 + EXTRA) begin
      failures++;
      $display("FAIL warm_len got=%0d want=%0d", hi, 5 + EXTRA);
    end
  endtask

  task automatic test_warm_in_hold();
    int t, fall;
    rst = 1'b1; step(); rst = 1'b0; pll_locked = 1'b1; warm_reset = 1'b1;
    t = e + 1;
    fall = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (fall < 0 && reset_out === 1'b0) begin fall = e; warm_reset = 1'b0; end
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        $display("FAIL warmhold_model i=%0d got=%b want=%b", i, act_o, exp_o);
      end
    end
    checks++;
    if (fall !== t + 2 + HOLD) begin
      failures++;
      $display("FAIL warmhold_fall got=%0d want=%0d", fall - t, 2 + HOLD);
    end
  endtask

  task automatic test_simul();
    wait_run();
    pll_locked = 1'b0; warm_reset = 1'b1;
    step();
    pll_locked = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) warm_reset = 1'b0;
      step();
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        $display("FAIL simul_model k=%0d got=%b want=%b", k, act_o, exp_o);
      end
    end
    checks++;
    if ({reset_out, cpu_reset} !== 2'b11) begin
      failures++;
      $display("FAIL simul_wait_lock got=%b want=11", {reset_out, cpu_reset});
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1; step(); rst = 1'b0; pll_locked = 1'b1; warm_reset = 1'b0;
    for (int i = 0; i < 40 && rel < 0; i++) step();
    for (int i = 0; i < int'($urandom_range(0, EXTRA - 2)); i++) step();
    rst = 1'b1;
    step();
    checks++;
    if (act_o !== 5'b11000) begin
      failures++;
      $display("FAIL rst_mid got=%b want=11000", act_o);
    end
    rst = 1'b0;
    for (int i = 0; i < HOLD + EXTRA + 6; i++) begin
      step();
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        $display("FAIL rst_restart i=%0d got=%b want=%b", i, act_o, exp_o);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      pll_locked = ($urandom_range(0, 59) != 0);
      warm_reset = ($urandom_range(0, 14) == 0);
      step();
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        $display("FAIL random_model i=%0d got=%b want=%b", i, act_o, exp_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; warm_reset = 1'b0;
    test_reset();
    test_cold_start();
    test_enable_phase();
    test_lock_loss();
    test_warm();
    test_warm_in_hold();
    test_simul();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
